// File: rtl/leaf_tile_switch.sv
// Leaf switch for one GPU tile: port 0 is the local NI, ports 1..NUM_SPINES are spine links.
// Per-input FIFOs with valid/ready, per-output round-robin arbitration and a registered output stage.
module leaf_tile_switch #(
    parameter int               DWIDTH     = 16,
    parameter int               ADDR_W     = 6,
    parameter int               GID_W      = 4,
    parameter logic [GID_W-1:0] GROUP_ID   = 4'b1000,
    parameter int               NUM_SPINES = 4,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [(NUM_SPINES+1)*DWIDTH-1:0]    in_data,
    input  logic [NUM_SPINES:0]                 in_valid,
    output logic [NUM_SPINES:0]                 in_ready,
    output logic [(NUM_SPINES+1)*DWIDTH-1:0]    out_data,
    output logic [NUM_SPINES:0]                 out_valid,
    input  logic [NUM_SPINES:0]                 out_ready,
    output logic [NUM_SPINES:0]                 fifo_full,
    output logic [15:0]                         drop_count,
    output logic                                busy
);

    localparam int NP  = NUM_SPINES + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int RW  = $clog2(NP);
    localparam int SW  = $clog2(NUM_SPINES);
    localparam int DCW = $clog2(NP + 1);

    // Handshake rule on every port: a transfer happens on a rising edge where
    // valid and ready are both high; valid/data are held until that edge.
    logic [DWIDTH-1:0] mem [NP][FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr [NP];
    logic [PW-1:0]     wr_ptr [NP];
    logic [CW-1:0]     count [NP];
    logic [DWIDTH-1:0] head [NP];
    logic [NP-1:0]     head_valid;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [NP-1:0]     drop;
    logic [NP-1:0]     can_load;
    logic [RW-1:0]     target [NP];
    logic [RW-1:0]     rr_ptr [NP];
    logic [NP-1:0]     grant_valid;
    logic [RW-1:0]     grant_idx [NP];
    logic [RW:0]       cand;
    logic [DCW-1:0]    n_drop;
    logic [16:0]       drop_sum;

    genvar gp;
    generate
        for (gp = 0; gp < NP; gp++) begin : g_port
            assign head[gp]       = mem[gp][rd_ptr[gp]];
            assign head_valid[gp] = (count[gp] != '0);
            assign fifo_full[gp]  = (count[gp] == CW'(FIFO_DEPTH));
            assign in_ready[gp]   = !fifo_full[gp];
            assign push[gp]       = in_valid[gp] & in_ready[gp];
            assign can_load[gp]   = !out_valid[gp] | out_ready[gp];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (reset) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end else begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
                if (push[p] && !pop[p])      count[p] <= count[p] + CW'(1);
                else if (!push[p] && pop[p]) count[p] <= count[p] - CW'(1);
            end
        end
    end

    // A foreign-group flit arriving from a spine has nowhere legal to go and is discarded.
    always_comb begin
        drop = '0;
        for (int p = 0; p < NP; p++) begin
            target[p] = '0;
            if (head[p][DWIDTH-1 -: GID_W] == GROUP_ID) begin
                target[p] = '0;
            end else if (p == 0) begin
                target[p] = RW'(1) + RW'(head[p][DWIDTH-ADDR_W +: SW]);
            end else begin
                drop[p] = head_valid[p];
            end
        end
    end

    always_comb begin
        grant_valid = '0;
        pop         = drop;
        cand        = '0;
        for (int o = 0; o < NP; o++) begin
            grant_idx[o] = '0;
            for (int k = 0; k < NP; k++) begin
                cand = {1'b0, rr_ptr[o]} + (RW+1)'(k);
                if (cand >= (RW+1)'(NP)) cand = cand - (RW+1)'(NP);
                if (!grant_valid[o] && can_load[o] && head_valid[cand[RW-1:0]] &&
                    !drop[cand[RW-1:0]] && (target[cand[RW-1:0]] == RW'(o))) begin
                    grant_valid[o] = 1'b1;
                    grant_idx[o]   = cand[RW-1:0];
                end
            end
            if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NP; o++) begin
            if (reset) begin
                out_valid[o]                   <= 1'b0;
                out_data[o*DWIDTH +: DWIDTH]   <= '0;
                rr_ptr[o]                      <= '0;
            end else if (grant_valid[o]) begin
                out_valid[o]                   <= 1'b1;
                out_data[o*DWIDTH +: DWIDTH]   <= head[grant_idx[o]];
                rr_ptr[o] <= (grant_idx[o] == RW'(NP-1)) ? '0 : grant_idx[o] + RW'(1);
            end else if (out_ready[o]) begin
                out_valid[o]                   <= 1'b0;
            end
        end
    end

    always_comb begin
        n_drop = '0;
        for (int p = 0; p < NP; p++) n_drop = n_drop + DCW'(drop[p]);
        drop_sum = {1'b0, drop_count} + 17'(n_drop);
    end

    always_ff @(posedge clk) begin
        if (reset)            drop_count <= '0;
        else if (drop_sum[16]) drop_count <= 16'hFFFF;
        else                  drop_count <= drop_sum[15:0];
    end

    assign busy = (|head_valid) | (|out_valid);

endmodule

// File: tb/tb_leaf_tile_switch.sv
// Scoreboard bench for leaf_tile_switch: drivers push expected flits per output,
// a negedge monitor pops and compares on every output handshake.
module tb_leaf_tile_switch;

    localparam int NP = 5;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP*DW-1:0] in_data = '0;
    logic [NP-1:0]    in_valid = '0;
    logic [NP-1:0]    in_ready;
    logic [NP*DW-1:0] out_data;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_ready = '1;
    logic [NP-1:0]    fifo_full;
    logic [15:0]      drop_count;
    logic             busy;

    logic [DW-1:0] exp_q [NP][$];
    logic [DW-1:0] mon_exp;
    logic [15:0]   exp_drop = '0;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int d0_count = 0;
    int d0_first = 0;
    int d0_last  = 0;

    leaf_tile_switch dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_full  (fifo_full),
        .drop_count (drop_count),
        .busy       (busy)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Monitor: one handshake per negedge where valid & ready are both high
    always @(negedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    n_checks++;
                    if (exp_q[o].size() == 0) begin
                        $display("FAIL out%0d_unexpected: got %h required none", o, out_data[o*DW +: DW]);
                    end else begin
                        mon_exp = exp_q[o].pop_front();
                        if (out_data[o*DW +: DW] === mon_exp) n_pass++;
                        else $display("FAIL out%0d_data: got %h required %h", o, out_data[o*DW +: DW], mon_exp);
                    end
                    if (o == 0) begin
                        if (d0_count == 0) d0_first = cyc;
                        d0_last = cyc;
                        d0_count++;
                    end
                end
            end
        end
    end

    // Reference routing for an accepted flit
    task automatic accept(input int p, input logic [DW-1:0] d);
        if (d[15:12] == 4'b1000)   exp_q[0].push_back(d);
        else if (p == 0)           exp_q[1 + int'(d[11:10])].push_back(d);
        else if (exp_drop != 16'hFFFF) exp_drop++;
    endtask

    task automatic clear_exp();
        for (int o = 0; o < NP; o++) exp_q[o].delete();
    endtask

    task automatic reset_dut();
        reset    = 1'b1;
        in_valid = '0;
        clear_exp();
        exp_drop = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_one(input int p, input logic [DW-1:0] d);
        bit acc = 0;
        in_valid[p]          = 1'b1;
        in_data[p*DW +: DW]  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready[p]) begin
                acc = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc) accept(p, d);
        else $display("FAIL send_port%0d: got no ready required ready", p);
        @(posedge clk);
        #1 in_valid[p] = 1'b0;
    endtask

    task automatic cycle_push(input logic [NP-1:0] vmask, input logic [DW-1:0] d [NP]);
        in_valid = vmask;
        for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = d[p];
        @(negedge clk);
        for (int p = 0; p < NP; p++) if (vmask[p] && in_ready[p]) accept(p, d[p]);
        @(posedge clk);
        #1 in_valid = '0;
    endtask

    task automatic wait_drain(input string name);
        bit empty = 0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge clk);
            empty = 1;
            for (int o = 0; o < NP; o++) if (exp_q[o].size() != 0) empty = 0;
        end
        check(name, 32'(empty), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus
    logic [DW-1:0] dv [NP];

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data[31:0]), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1F);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;

        // Local flit: out_valid two edges after the input handshake
        send_one(0, {6'b10_0000, 10'h1A5});
        @(negedge clk);
        check("t1_latency_early", 32'(out_valid[0]), 32'h0);
        @(negedge clk);
        check("t1_latency_valid", 32'(out_valid[0]), 32'h1);
        wait_drain("t1_drain");
        check("t1_drop_count", 32'(drop_count), 32'h0);

        // Foreign flit from local port goes to spine output 1 + 2
        send_one(0, {6'b01_0010, 10'h2C3});
        wait_drain("t2_drain");
        check("t2_drop_count", 32'(drop_count), 32'h0);

        // Misroute from a spine, then saturation with four spines in parallel
        send_one(2, {6'b01_0001, 10'h055});
        repeat (3) @(negedge clk);
        check("t3_drop_one", 32'(drop_count), 32'h1);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) dv[p] = {6'b01_0001, 10'h0AA};
        for (int i = 0; i < 16385; i++) begin
            cycle_push(5'b11110, dv);
            if (i == 999) begin
                repeat (3) @(negedge clk);
                check("t3_drop_4001", 32'(drop_count), 32'd4001);
                @(posedge clk);
                #1;
            end
        end
        repeat (3) @(negedge clk);
        check("t3_drop_saturated", 32'(drop_count), 32'hFFFF);
        check("t3_drop_model", 32'(drop_count), 32'(exp_drop));
        @(posedge clk);
        #1;

        // All five inputs to local: round-robin 0..4, one flit per cycle
        reset_dut();
        d0_count = 0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) dv[p] = {6'b10_0000, 6'(p), 4'(r)};
            cycle_push(5'b11111, dv);
        end
        wait_drain("t4_drain");
        check("t4_delivered", 32'(d0_count), 32'd10);
        check("t4_back_to_back", 32'(d0_last - d0_first), 32'd9);

        // Back-pressure on output 0
        out_ready = 5'b11110;
        for (int i = 0; i < 5; i++) send_one(1, {6'b10_0001, 6'd0, 4'(i)});
        @(negedge clk);
        check("t5_fifo_full", 32'(fifo_full[1]), 32'h1);
        check("t5_in_ready", 32'(in_ready[1]), 32'h0);
        check("t5_out_valid", 32'(out_valid[0]), 32'h1);
        check("t5_out_data", 32'(out_data[15:0]), 32'h8400);
        repeat (3) @(negedge clk);
        check("t5_out_data_held", 32'(out_data[15:0]), 32'h8400);
        check("t5_still_full", 32'(fifo_full[1]), 32'h1);
        @(posedge clk);
        #1 out_ready = '1;
        send_one(1, {6'b10_0001, 6'd0, 4'd5});
        wait_drain("t5_drain");

        // Reset mid-operation discards everything
        out_ready = '0;
        send_one(1, 16'h8111);
        send_one(1, 16'h8112);
        send_one(1, 16'h8113);
        send_one(3, 16'h8333);
        reset = 1'b1;
        clear_exp();
        exp_drop = '0;
        @(posedge clk);
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'h0);
        check("t6_in_ready", 32'(in_ready), 32'h1F);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_fifo_full", 32'(fifo_full), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = '1;
        repeat (10) @(negedge clk);
        check("t6_no_stale", 32'(busy), 32'h0);
        check("t6_drop_count", 32'(drop_count), 32'h0);
        @(posedge clk);
        #1;
        send_one(4, {6'b10_0000, 10'h3EE});
        wait_drain("t6_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
